// File: rtl/sram_responder_if.sv
// SRAM-style bus between the CPU memory port (MAR/MDR side) and the responder.
interface sram_responder_if;
    logic        Mem_CE;
    logic        Mem_OE;
    logic        Mem_WE;
    logic        Mem_UB;
    logic        Mem_LB;
    logic [15:0] ADDR;
    logic [15:0] Data_in;
    logic [15:0] Data_out;
    logic        Rd_valid;

    modport master (
        output Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB, ADDR, Data_in,
        input  Data_out, Rd_valid
    );

    modport slave (
        input  Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB, ADDR, Data_in,
        output Data_out, Rd_valid
    );
endinterface

// File: rtl/sram_responder.sv
// Synchronous SRAM responder: on-chip word array plus one memory-mapped I/O word
// (Switches on read, Hex_out on write). Reads need two OE-low edges before data is
// valid; writes need WE low across three edges and commit exactly once per strobe.
module sram_responder #(
    parameter int unsigned DEPTH_BITS = 8,
    parameter logic [15:0] IO_ADDR    = 16'hFFFF
) (
    input  logic                    Clk,
    input  logic                    Reset,
    sram_responder_if.slave         bus,
    input  logic [15:0]             Switches,
    output logic [15:0]             Hex_out
);

    localparam int unsigned Words = 1 << DEPTH_BITS;

    typedef enum logic [2:0] {
        StIdle,
        StRd1,
        StRd2,
        StWr1,
        StWr2,
        StWrHold
    } state_e;

    state_e      state_q;
    logic [15:0] data_out_q;
    logic        rd_valid_q;
    logic [15:0] hex_out_q;

    // Power-up contents are zero from the configuration image; reset never clears it.
    logic [15:0] mem [Words];

    logic                  is_io;
    logic                  in_range;
    logic [DEPTH_BITS-1:0] idx;
    logic [15:0]           rd_word;
    logic                  commit;

    // Byte-lane merge; lane enables are active-low, both high leaves the word unchanged.
    function automatic logic [15:0] merge_lanes(input logic [15:0] old_w,
                                                input logic [15:0] new_w,
                                                input logic        ub_n,
                                                input logic        lb_n);
        return {ub_n ? old_w[15:8] : new_w[15:8], lb_n ? old_w[7:0] : new_w[7:0]};
    endfunction

    // Address decode and the word a read would return this cycle.
    always_comb begin
        is_io    = (bus.ADDR == IO_ADDR);
        in_range = ({16'h0000, bus.ADDR} < Words);
        idx      = bus.ADDR[DEPTH_BITS-1:0];
        rd_word  = 16'h0000;
        if (is_io) begin
            rd_word = Switches;
        end else if (in_range) begin
            rd_word = mem[idx];
        end
        // Only the edge ending WR2 with the strobe still held may write.
        commit = (state_q == StWr2) && !Reset && !bus.Mem_CE && !bus.Mem_WE;
    end

    // Array write port; the I/O address takes priority even if it aliases the array.
    always_ff @(posedge Clk) begin
        if (commit && in_range && !is_io) begin
            mem[idx] <= merge_lanes(mem[idx], bus.Data_in, bus.Mem_UB, bus.Mem_LB);
        end
    end

    // Bus FSM with registered read data, read-valid flag and hex register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= StIdle;
            data_out_q <= 16'h0000;
            rd_valid_q <= 1'b0;
            hex_out_q  <= 16'h0000;
        end else if (bus.Mem_CE) begin
            state_q    <= StIdle;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    // WE wins over OE, so a combined strobe is a write.
                    if (!bus.Mem_WE) begin
                        state_q <= StWr1;
                    end else if (!bus.Mem_OE) begin
                        state_q <= StRd1;
                    end
                end
                StRd1: begin
                    data_out_q <= rd_word;
                    if (!bus.Mem_OE) begin
                        state_q    <= StRd2;
                        rd_valid_q <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRd2: begin
                    if (!bus.Mem_OE) begin
                        data_out_q <= rd_word;
                        rd_valid_q <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StWr1: begin
                    state_q <= !bus.Mem_WE ? StWr2 : StIdle;
                end
                StWr2: begin
                    if (!bus.Mem_WE) begin
                        state_q <= StWrHold;
                        if (is_io) begin
                            hex_out_q <= merge_lanes(hex_out_q, bus.Data_in,
                                                     bus.Mem_UB, bus.Mem_LB);
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StWrHold: begin
                    if (bus.Mem_WE) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.Data_out = data_out_q;
    assign bus.Rd_valid = rd_valid_q;
    assign Hex_out      = hex_out_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed plus randomized bench for sram_responder against a word-level memory model.
module tb_sram_responder;

    logic        Clk;
    logic        Reset;
    logic [15:0] Switches;
    logic [15:0] Hex_out;

    sram_responder_if bus ();

    sram_responder #(
        .DEPTH_BITS (8),
        .IO_ADDR    (16'hFFFF)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .bus      (bus),
        .Switches (Switches),
        .Hex_out  (Hex_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // Reference model: sparse word store, hex register.
    logic [15:0] mem_m [int];
    logic [15:0] hex_m = 16'h0000;

    logic [15:0] pool [14] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0005, 16'h0007,
                               16'h0010, 16'h0012, 16'h0013, 16'h00FF, 16'hFFFF, 16'h0100,
                               16'h1234, 16'h8000};

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_word(input logic [15:0] a);
        if (a == 16'hFFFF) return hex_m;
        if (a < 16'h0100 && mem_m.exists(int'(a))) return mem_m[int'(a)];
        return 16'h0000;
    endfunction

    function automatic logic [15:0] exp_rd(input logic [15:0] a);
        if (a == 16'hFFFF) return Switches;
        if (a < 16'h0100) return model_word(a);
        return 16'h0000;
    endfunction

    task automatic model_commit(input logic [15:0] a, input logic [15:0] d,
                                input logic ub, input logic lb);
        logic [15:0] w;
        w = model_word(a);
        if (!ub) w[15:8] = d[15:8];
        if (!lb) w[7:0]  = d[7:0];
        if (a == 16'hFFFF) hex_m = w;
        else if (a < 16'h0100) mem_m[int'(a)] = w;
    endtask

    // WE held low across n edges, then released for one edge back to idle.
    task automatic wr(input logic [15:0] a, input logic [15:0] d,
                      input logic ub, input logic lb, input int n);
        bus.Mem_CE = 1'b0; bus.Mem_OE = 1'b1; bus.Mem_WE = 1'b0;
        bus.Mem_UB = ub;   bus.Mem_LB = lb;   bus.ADDR = a; bus.Data_in = d;
        repeat (n) tick();
        bus.Mem_WE = 1'b1;
        tick();
        if (n >= 3) model_commit(a, d, ub, lb);
        chk("wr_hex", Hex_out, hex_m);
        chk("wr_rdvalid", {15'h0, bus.Rd_valid}, 16'h0000);
    endtask

    // OE low for two edges, data checked in the second OE cycle, then released.
    task automatic rd(input string tag, input logic [15:0] a);
        bus.Mem_CE = 1'b0; bus.Mem_WE = 1'b1; bus.Mem_OE = 1'b0; bus.ADDR = a;
        tick();
        chk("rd1_valid", {15'h0, bus.Rd_valid}, 16'h0000);
        tick();
        chk(tag, bus.Data_out, exp_rd(a));
        chk("rd2_valid", {15'h0, bus.Rd_valid}, 16'h0001);
        bus.Mem_OE = 1'b1;
        tick();
        chk("rd_end_valid", {15'h0, bus.Rd_valid}, 16'h0000);
    endtask

    initial begin
        logic [15:0] hold;
        logic [15:0] a;
        Reset = 1'b1; Switches = 16'h0000;
        bus.Mem_CE = 1'b1; bus.Mem_OE = 1'b1; bus.Mem_WE = 1'b1;
        bus.Mem_UB = 1'b0; bus.Mem_LB = 1'b0; bus.ADDR = '0; bus.Data_in = '0;
        tick(); tick();
        chk("rst_dout", bus.Data_out, 16'h0000);
        chk("rst_valid", {15'h0, bus.Rd_valid}, 16'h0000);
        chk("rst_hex", Hex_out, 16'h0000);
        Reset = 1'b0;
        tick();

        // Known contents for every in-range pool address.
        foreach (pool[i]) if (pool[i] < 16'h0100) wr(pool[i], 16'h1100 + 16'(i), 1'b0, 1'b0, 3);

        // Write then read.
        wr(16'h0012, 16'hBEEF, 1'b0, 1'b0, 3);
        rd("wr_rd", 16'h0012);
        chk("beef", bus.Data_out, 16'hBEEF);

        // Byte lanes.
        wr(16'h0005, 16'h1234, 1'b0, 1'b0, 3);
        wr(16'h0005, 16'hABCD, 1'b1, 1'b0, 3);
        rd("lane_rd", 16'h0005);
        chk("lane_12cd", bus.Data_out, 16'h12CD);
        wr(16'h0005, 16'h5555, 1'b1, 1'b1, 4);
        rd("lane_noop", 16'h0005);

        // I/O mapping.
        wr(16'hFFFF, 16'h00A5, 1'b0, 1'b0, 3);
        chk("hex_a5", Hex_out, 16'h00A5);
        Switches = 16'h3C3C;
        rd("io_rd", 16'hFFFF);
        chk("sw_3c3c", bus.Data_out, 16'h3C3C);

        // Rejected writes: short pulses and CE high.
        wr(16'h0005, 16'hFFFF, 1'b0, 1'b0, 1);
        wr(16'h0005, 16'hFFFF, 1'b0, 1'b0, 2);
        rd("short_rej", 16'h0005);
        hold = bus.Data_out;
        bus.Mem_CE = 1'b1; bus.Mem_WE = 1'b0; bus.Mem_OE = 1'b0;
        bus.ADDR = 16'h0005; bus.Data_in = 16'h0F0F;
        repeat (3) tick();
        chk("ce_dout_hold", bus.Data_out, hold);
        chk("ce_valid", {15'h0, bus.Rd_valid}, 16'h0000);
        chk("ce_hex_hold", Hex_out, hex_m);
        bus.Mem_WE = 1'b1; bus.Mem_OE = 1'b1; bus.Mem_CE = 1'b0;
        tick();
        rd("ce_rej", 16'h0005);
        chk("ce_12cd", bus.Data_out, 16'h12CD);

        // Reset during WR1 blocks the commit.
        bus.Mem_WE = 1'b0; bus.ADDR = 16'h0003; bus.Data_in = 16'h7777;
        bus.Mem_UB = 1'b0; bus.Mem_LB = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        chk("wrst_dout", bus.Data_out, 16'h0000);
        chk("wrst_hex", Hex_out, 16'h0000);
        chk("wrst_valid", {15'h0, bus.Rd_valid}, 16'h0000);
        hex_m = 16'h0000;
        Reset = 1'b0; bus.Mem_WE = 1'b1;
        tick();
        rd("wrst_keep", 16'h0003);

        // Out-of-range write discarded.
        wr(16'h0100, 16'h9999, 1'b0, 1'b0, 3);
        rd("oor_rd", 16'h0100);
        chk("oor_zero", bus.Data_out, 16'h0000);
        rd("oor_alias", 16'h0000);

        // Aborted read: sample taken, valid never rises.
        bus.Mem_OE = 1'b0; bus.ADDR = 16'h0012;
        tick();
        bus.Mem_OE = 1'b1;
        tick();
        chk("abort_dout", bus.Data_out, exp_rd(16'h0012));
        chk("abort_valid", {15'h0, bus.Rd_valid}, 16'h0000);

        // OE and WE together act as a write.
        bus.Mem_OE = 1'b0; bus.Mem_WE = 1'b0; bus.ADDR = 16'h0007; bus.Data_in = 16'hC0DE;
        repeat (3) begin
            tick();
            chk("both_valid", {15'h0, bus.Rd_valid}, 16'h0000);
        end
        bus.Mem_OE = 1'b1; bus.Mem_WE = 1'b1;
        tick();
        model_commit(16'h0007, 16'hC0DE, 1'b0, 1'b0);
        rd("both_rd", 16'h0007);

        // Address change while in RD2 shows one cycle later.
        bus.Mem_OE = 1'b0; bus.ADDR = 16'h0005;
        tick(); tick();
        chk("mid_a", bus.Data_out, exp_rd(16'h0005));
        bus.ADDR = 16'h0012;
        tick();
        chk("mid_b", bus.Data_out, exp_rd(16'h0012));
        chk("mid_valid", {15'h0, bus.Rd_valid}, 16'h0001);
        bus.Mem_OE = 1'b1;
        tick();

        // Randomized traffic over the address pool.
        for (int k = 0; k < 60; k++) begin
            a = pool[$urandom_range(0, 13)];
            if ($urandom_range(0, 1) == 0) begin
                wr(a, 16'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(1, 4)));
            end else begin
                Switches = 16'($urandom);
                rd("rand_rd", a);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 SHALL have parameter DEPTH_BITS, default 8: on-chip word array holds 2**DEPTH_BITS 16-bit words.
REQ-002 SHALL have parameter IO_ADDR, default 16'hFFFF: memory-mapped switch/hex-display address.
REQ-003 SHALL have port Clk, input, 1: clock; all state updates on the rising edge.
REQ-004 SHALL have port Reset, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port Mem_CE, input, 1: chip enable, active-low.
REQ-006 SHALL have port Mem_OE, input, 1: output enable (read strobe), active-low.
REQ-007 SHALL have port Mem_WE, input, 1: write enable, active-low.
REQ-008 SHALL have ports Mem_UB and Mem_LB, input, 1 each: upper/lower byte-lane enables, active-low.
REQ-009 SHALL have port ADDR, input, 16: word address, driven from MAR.
REQ-010 SHALL have port Data_in, input, 16: write data, driven from MDR.
REQ-011 SHALL have port Data_out, output, 16: registered read data.
REQ-012 SHALL have port Switches, input, 16: value returned on reads of IO_ADDR.
REQ-013 SHALL have port Hex_out, output, 16: register loaded by writes to IO_ADDR.
REQ-014 SHALL have port Rd_valid, output, 1: Data_out holds data for the current read.

Function
REQ-015 SHALL implement FSM states IDLE, RD1, RD2, WR1, WR2, WR_HOLD.
REQ-016 SHALL ignore every strobe while Mem_CE=1; any state goes to IDLE next cycle, Data_out and Hex_out hold.
REQ-017 IDLE: Mem_WE=0 -> WR1; otherwise Mem_OE=0 -> RD1; otherwise stay in IDLE.
REQ-018 RD1: SHALL register the read word into Data_out at the edge ending RD1, then go to RD2; Rd_valid=1 throughout RD2, so data is stable during the 2nd consecutive OE-low cycle.
REQ-019 RD2: while Mem_OE=0, SHALL stay in RD2 and re-sample the addressed word every cycle; Mem_OE=1 -> IDLE with Rd_valid=0.
REQ-020 Mem_OE=1 during RD1 (aborted read) SHALL return to IDLE; Data_out holds the new sample and Rd_valid stays 0.
REQ-021 Read source: ADDR==IO_ADDR -> Switches; ADDR < 2**DEPTH_BITS -> array[ADDR]; any other address -> 16'h0000.
REQ-022 WR1 -> WR2 if Mem_WE=0, else IDLE with no write (a one-cycle pulse is rejected).
REQ-023 At the edge ending WR2, if Mem_WE is still 0, SHALL commit exactly one write, then go to WR_HOLD; if Mem_WE=1, SHALL go to IDLE with no write.
REQ-024 WR_HOLD SHALL persist while Mem_WE=0 with no further commit; Mem_WE=1 -> IDLE.
REQ-025 Commit SHALL use the ADDR and Data_in values present in WR2.
REQ-026 Byte-lane rules: Mem_UB=0 writes bits [15:8], Mem_LB=0 writes bits [7:0], both high makes the write a no-op; reads always return all 16 bits.
REQ-027 Commit target: IO_ADDR -> Hex_out (byte lanes apply); in-range address -> array; out-of-range address -> discarded.
REQ-028 Mem_OE=0 and Mem_WE=0 together SHALL be handled as a write; no read occurs and Rd_valid=0.
REQ-029 A read of the address just committed, starting the cycle after WR_HOLD, SHALL return the new data (no stale bypass hazard).
REQ-030 Address changes mid-read in RD2 SHALL appear on Data_out one cycle later.

Reset
REQ-031 Reset=1 SHALL force state IDLE, Data_out=16'h0000, Rd_valid=0, Hex_out=16'h0000 at the next edge, overriding all strobes.
REQ-032 Reset asserted mid-write before the WR2 edge SHALL prevent the commit; reset SHALL NOT clear array contents.
REQ-033 Array SHALL power up at all zeros.

Verification
REQ-034 Write then read: ADDR=16'h0012, Data_in=16'hBEEF, WE low for 3 cycles, then OE low for 2 cycles -> Data_out=16'hBEEF with Rd_valid=1 in the 2nd OE cycle.
REQ-035 Byte lanes: array[5]=16'h1234, write 16'hABCD with Mem_UB=1, Mem_LB=0 -> read returns 16'h12CD.
REQ-036 I/O mapping: write 16'h00A5 to 16'hFFFF -> Hex_out=16'h00A5; Switches=16'h3C3C, read 16'hFFFF -> Data_out=16'h3C3C.
REQ-037 Rejected writes: 1-cycle WE pulse, and Mem_CE=1 with 3-cycle WE low -> target word unchanged.
REQ-038 Reset: assert Reset during WR1 of a write of 16'h7777 to 16'h0003 -> state IDLE, Data_out=0, Hex_out=0; later read of 16'h0003 returns its prior value.
REQ-039 Out-of-range: with DEPTH_BITS=8, write to 16'h0100, then read it -> Data_out=16'h0000, and array[0] is unchanged.
